// File: rtl/cmd_rx_pkg.sv
// Shared types and constants for the SUMP host-command assembler.
package cmd_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    EXEC = 2'd2
  } state_t;

  localparam int unsigned LONG_CMD_BIT = 7;
  localparam int unsigned DATA_BYTES   = 4;

  localparam logic [7:0] OP_RESET = 8'h00;
  localparam logic [7:0] OP_RUN   = 8'h01;

endpackage

// File: rtl/cmd_rx_timeout.sv
// Inter-byte idle counter for long commands: clears on activity, expires after TIMEOUT_CYC idle cycles.
module cmd_rx_timeout #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned TW          = 20
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_active,
  input  logic i_accept,
  output logic o_expire
);

  localparam logic [TW-1:0] LAST_IDLE = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (!i_active || i_accept) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + TW'(1);
    end
  end

  // An accepted byte in the expiring cycle suppresses the timeout.
  assign o_expire = i_active && !i_accept && (r_count == LAST_IDLE);

endmodule

// File: rtl/cmd_rx.sv
// SUMP command framer: assembles 1-byte short / 5-byte long commands and strobes execute.
// Optional inter-byte timeout enabled by defining CMD_RX_TIMEOUT_EN.
module cmd_rx
  import cmd_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned TW          = 20
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  opcode,
  output logic [31:0] config_data,
  output logic        execute,
  output logic        cmd_abort
);

  state_t        r_state;
  state_t        w_next_state;
  logic [7:0]    r_shadow_op;
  logic [23:0]   r_shadow_data;
  logic [1:0]    r_idx;
  logic [7:0]    r_opcode;
  logic [31:0]   r_config;
  logic          w_accept;
  logic          w_last_byte;
  logic          w_expire;

  assign w_accept    = rx_valid && rx_ready;
  assign w_last_byte = (r_idx == 2'(DATA_BYTES - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = rx_data[LONG_CMD_BIT] ? DATA : EXEC;
        end
      end
      DATA: begin
        if (w_accept && w_last_byte) begin
          w_next_state = EXEC;
        end else if (w_expire) begin
          w_next_state = IDLE;
        end
      end
      EXEC:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    rx_ready = (r_state != EXEC);
    execute  = (r_state == EXEC);
  end

  // NOTE: the shadow registers are small and the reset state is observable
  // (index must restart at 0), so they take the async reset like the rest.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_shadow_op   <= '0;
      r_shadow_data <= '0;
      r_idx         <= '0;
      r_opcode      <= '0;
      r_config      <= '0;
    end else begin
      if (r_state == IDLE && w_accept) begin
        r_shadow_op <= rx_data;
        r_idx       <= '0;
        if (!rx_data[LONG_CMD_BIT]) begin
          r_opcode <= rx_data;
        end
      end
      if (r_state == DATA && w_accept) begin
        r_idx <= r_idx + 2'd1;
        // The final byte goes straight to the output so execute sees the full word.
        unique case (r_idx)
          2'd0:    r_shadow_data[7:0]   <= rx_data;
          2'd1:    r_shadow_data[15:8]  <= rx_data;
          2'd2:    r_shadow_data[23:16] <= rx_data;
          default: begin
            r_opcode <= r_shadow_op;
            r_config <= {rx_data, r_shadow_data};
          end
        endcase
      end
      if (w_expire) begin
        r_shadow_data <= '0;
        r_idx         <= '0;
      end
    end
  end

  assign opcode      = r_opcode;
  assign config_data = r_config;

`ifdef CMD_RX_TIMEOUT_EN
  logic w_in_data;
  logic r_cmd_abort;

  assign w_in_data = (r_state == DATA);

  cmd_rx_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TW          (TW)
  ) u_timeout (
    .i_clk    (sys_clk),
    .i_rst_n  (sys_rst_n),
    .i_active (w_in_data),
    .i_accept (w_accept),
    .o_expire (w_expire)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cmd_abort <= 1'b0;
    end else begin
      r_cmd_abort <= w_expire;
    end
  end

  assign cmd_abort = r_cmd_abort;
`else
  logic w_unused_cfg;

  // Timeout parameters only matter when the counter is built.
  assign w_unused_cfg = ^{TIMEOUT_CYC, TW};
  assign w_expire     = 1'b0;
  assign cmd_abort    = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_rx.sv
// Self-checking bench for cmd_rx: directed vector table, multi-cycle sequences and random traffic.
module tb_cmd_rx;
  import cmd_rx_pkg::*;

  localparam int unsigned T_CYC = 16;
`ifdef CMD_RX_TIMEOUT_EN
  localparam int GAP_MAX  = 12;
  localparam int RAND_GAP = 4;
`else
  localparam int GAP_MAX  = 20;
  localparam int RAND_GAP = 6;
`endif

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [7:0]  rx_data   = 8'h00;
  logic        rx_valid  = 1'b0;
  logic        rx_ready;
  logic [7:0]  opcode;
  logic [31:0] config_data;
  logic        execute;
  logic        cmd_abort;

  cmd_rx #(
    .TIMEOUT_CYC (T_CYC),
    .TW          (5)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .opcode      (opcode),
    .config_data (config_data),
    .execute     (execute),
    .cmd_abort   (cmd_abort)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a command is a list of bytes; it completes when the first
  // byte is short or five bytes are collected. Outputs hold the last completed command.
  logic [7:0]  part[$];
  logic        exp_exec = 1'b0;
  logic [7:0]  pend_op  = 8'h00;
  logic [31:0] pend_cfg = 32'h0;
  logic [7:0]  held_op  = 8'h00;
  logic [31:0] held_cfg = 32'h0;
  logic        mon_en   = 1'b0;
  int          cyc      = 0;
  int          exec_cnt = 0;
  int          abort_cnt = 0;
  int          exec_cyc[$];
  logic [7:0]  exec_ops[$];

  function automatic void model_accept(input logic [7:0] b);
    part.push_back(b);
    if (!part[0][7]) begin
      pend_op  = part[0];
      pend_cfg = held_cfg;
      exp_exec = 1'b1;
      part.delete();
    end else if (part.size() == 5) begin
      pend_op  = part[0];
      pend_cfg = {part[4], part[3], part[2], part[1]};
      exp_exec = 1'b1;
      part.delete();
    end
  endfunction

  function automatic void model_reset();
    part.delete();
    exp_exec = 1'b0;
    held_op  = 8'h00;
    held_cfg = 32'h0;
  endfunction

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (mon_en) begin
      check("exec_strobe", 32'(execute), 32'(exp_exec));
      check("rx_ready", 32'(rx_ready), 32'(!exp_exec));
      if (exp_exec) begin
        held_op  = pend_op;
        held_cfg = pend_cfg;
      end
      if (execute) begin
        exec_cnt++;
        exec_cyc.push_back(cyc);
        exec_ops.push_back(opcode);
      end
      if (cmd_abort) abort_cnt++;
      check("opcode_hold", 32'(opcode), 32'(held_op));
      check("config_hold", config_data, held_cfg);
      exp_exec = 1'b0;
    end
  end

  // Present a byte after 'gap' idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge sys_clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 10) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 10) begin
      check("accept_timeout", 32'(n), 32'(0));
    end else begin
      @(posedge sys_clk);
      model_accept(b);
    end
    @(negedge sys_clk);
    rx_valid = 1'b0;
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [39:0] bytes;
    logic [7:0]  exp_op;
    logic [31:0] exp_cfg;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected end earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_exec;
    int base_abort;
    int n_cmds;

    vecs[0] = '{"setup_long", 5, 40'hDEADBEEFC0, 8'hC0, 32'hDEADBEEF};
    vecs[1] = '{"short_run",  1, 40'h0000000001, OP_RUN, 32'hDEADBEEF};
    vecs[2] = '{"long_c0",    5, 40'h12345678C0, 8'hC0, 32'h12345678};
    vecs[3] = '{"short_rst",  1, 40'h0000000000, OP_RESET, 32'h12345678};
    vecs[4] = '{"long_ff",    5, 40'hDDCCBBAAFF, 8'hFF, 32'hDDCCBBAA};
    vecs[5] = '{"short_7f",   1, 40'h000000007F, 8'h7F, 32'hDDCCBBAA};

    // Reset values
    repeat (2) @(negedge sys_clk);
    check("rst_ready", 32'(rx_ready), 32'(1));
    check("rst_opcode", 32'(opcode), 32'(0));
    check("rst_config", config_data, 32'(0));
    check("rst_execute", 32'(execute), 32'(0));
    check("rst_abort", 32'(cmd_abort), 32'(0));
    sys_rst_n = 1'b1;
    mon_en    = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        send_byte(vecs[i].bytes[8*k +: 8], 0);
      end
      check({vecs[i].name, "_exec"}, 32'(execute), 32'(1));
      check({vecs[i].name, "_ready"}, 32'(rx_ready), 32'(0));
      check({vecs[i].name, "_op"}, 32'(opcode), 32'(vecs[i].exp_op));
      check({vecs[i].name, "_cfg"}, config_data, vecs[i].exp_cfg);
      @(negedge sys_clk);
      check({vecs[i].name, "_one_cycle"}, 32'(execute), 32'(0));
      repeat (2) @(negedge sys_clk);
    end

    // Back-to-back short commands including the SUMP reset sequence
    base_exec = exec_cyc.size();
    for (int i = 0; i < 5; i++) send_byte(OP_RESET, 0);
    send_byte(8'h02, 0);
    repeat (3) @(negedge sys_clk);
    check("b2b_count", 32'(exec_cyc.size() - base_exec), 32'(6));
    if (exec_cyc.size() - base_exec == 6) begin
      for (int i = 1; i < 6; i++) begin
        check("b2b_spacing", 32'(exec_cyc[base_exec+i] - exec_cyc[base_exec+i-1]), 32'(2));
      end
      for (int i = 0; i < 6; i++) begin
        check("b2b_opcode", 32'(exec_ops[base_exec+i]), (i < 5) ? 32'(OP_RESET) : 32'h02);
      end
    end

    // Long command with random inter-byte gaps
    send_byte(8'h81, $urandom_range(GAP_MAX, 0));
    send_byte(8'h11, $urandom_range(GAP_MAX, 0));
    send_byte(8'h22, $urandom_range(GAP_MAX, 0));
    send_byte(8'h33, $urandom_range(GAP_MAX, 0));
    send_byte(8'h44, $urandom_range(GAP_MAX, 0));
    check("gaps_exec", 32'(execute), 32'(1));
    check("gaps_op", 32'(opcode), 32'h81);
    check("gaps_cfg", config_data, 32'h44332211);
    repeat (3) @(negedge sys_clk);

`ifdef CMD_RX_TIMEOUT_EN
    // Abandoned long command
    base_exec  = exec_cnt;
    base_abort = abort_cnt;
    send_byte(8'h80, 0);
    send_byte(8'hAA, 0);
    repeat (T_CYC - 1) @(negedge sys_clk);
    check("abort_not_early", 32'(abort_cnt), 32'(base_abort));
    @(negedge sys_clk);
    check("abort_pulse", 32'(cmd_abort), 32'(1));
    part.delete();
    @(negedge sys_clk);
    check("abort_one_cycle", 32'(cmd_abort), 32'(0));
    repeat (4) @(negedge sys_clk);
    check("abort_count", 32'(abort_cnt - base_abort), 32'(1));
    check("abort_no_exec", 32'(exec_cnt - base_exec), 32'(0));
    send_byte(OP_RUN, 0);
    check("post_abort_op", 32'(opcode), 32'(OP_RUN));
    check("post_abort_cfg", config_data, 32'h44332211);
    repeat (3) @(negedge sys_clk);
`endif

    // Reset in the middle of a long command
    send_byte(8'hC2, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    mon_en = 1'b0;
    #2 sys_rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(rx_ready), 32'(1));
    check("midrst_opcode", 32'(opcode), 32'(0));
    check("midrst_config", config_data, 32'(0));
    check("midrst_execute", 32'(execute), 32'(0));
    check("midrst_abort", 32'(cmd_abort), 32'(0));
    model_reset();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    mon_en    = 1'b1;
    repeat (2) @(negedge sys_clk);
    send_byte(8'h03, 0);
    check("postrst_op", 32'(opcode), 32'h03);
    check("postrst_cfg", config_data, 32'(0));
    repeat (2) @(negedge sys_clk);

    // Random command traffic against the model
    base_exec = exec_cnt;
    n_cmds    = 300;
    for (int c = 0; c < n_cmds; c++) begin
      logic [7:0] op;
      op = 8'($urandom_range(255, 0));
      send_byte(op, $urandom_range(RAND_GAP, 0));
      if (op[7]) begin
        for (int k = 0; k < 4; k++) begin
          send_byte(8'($urandom_range(255, 0)), $urandom_range(RAND_GAP, 0));
        end
      end
    end
    repeat (4) @(negedge sys_clk);
    check("rand_exec_count", 32'(exec_cnt - base_exec), 32'(n_cmds));
    check("no_partial_left", 32'(part.size()), 32'(0));
`ifdef CMD_RX_TIMEOUT_EN
    check("total_aborts", 32'(abort_cnt), 32'(1));
`else
    check("total_aborts", 32'(abort_cnt), 32'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
